// File: rtl/cbus_pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cbus_pipe_ctrl_pkg
// Shared definitions for the CBus pipeline controller: bus and register
// address widths, CBus field positions, the DdataSel "load" code and the EX
// operand-forwarding select codes, plus the forwarding priority function.
// -----------------------------------------------------------------------------
package cbus_pipe_ctrl_pkg;

    localparam int CBUS_W = 18;
    localparam int RA_W   = 5;

    // CBus field map
    localparam int CB_IMMSRC_LO = 0;
    localparam int CB_IMMSRC_HI = 2;
    localparam int CB_ASRC      = 3;
    localparam int CB_BSRC      = 4;
    localparam int CB_REGWEN    = 5;
    localparam int CB_MEMWEN    = 6;
    localparam int CB_DSEL_LO   = 7;
    localparam int CB_DSEL_HI   = 8;
    localparam int CB_ALUOP_LO  = 9;
    localparam int CB_ALUOP_HI  = 12;
    localparam int CB_BRANCH    = 13;
    localparam int CB_JUMP      = 14;
    localparam int CB_BRU       = 15;
    localparam int CB_BRT_LO    = 16;
    localparam int CB_BRT_HI    = 17;

    // DdataSel code for "writeback from data memory"
    localparam logic [1:0] DSEL_MEM = 2'b01;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // Operand source for one EX source register. The younger producer (MEM)
    // wins over the older one (WB); x0 is hard-wired zero and never forwards.
    function automatic fwd_sel_e fwd_pick(
        input logic            ex_valid,
        input logic [RA_W-1:0] rs,
        input logic            mem_wen,
        input logic [RA_W-1:0] mem_rd,
        input logic            wb_wen,
        input logic [RA_W-1:0] wb_rd
    );
        fwd_pick = FWD_RF;
        if (ex_valid && (rs != '0)) begin
            if (mem_wen && (mem_rd == rs))
                fwd_pick = FWD_MEM;
            else if (wb_wen && (wb_rd == rs))
                fwd_pick = FWD_WB;
        end
    endfunction

endpackage

// File: rtl/cbus_stage_reg.sv
// -----------------------------------------------------------------------------
// cbus_stage_reg
// One pipeline stage register holding valid, CBus and destination register.
// Loads the upstream value every cycle, or a bubble (all zero) when bubble or
// the synchronous reset is asserted.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   bubble   in   load a bubble instead of the upstream value
//   valid_d  in   upstream valid
//   cbus_d   in   upstream CBus
//   rd_d     in   upstream destination register
//   valid_q, cbus_q, rd_q   out   registered stage contents
// -----------------------------------------------------------------------------
module cbus_stage_reg
    import cbus_pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              valid_d,
    input  logic [CBUS_W-1:0] cbus_d,
    input  logic [RA_W-1:0]   rd_d,
    output logic              valid_q,
    output logic [CBUS_W-1:0] cbus_q,
    output logic [RA_W-1:0]   rd_q
);

    // NOTE: every field is cleared, not just valid: downstream logic reads
    // RegWEn/MemWEn/Branch/Jump straight from cbus, so a bubble must carry
    // all-zero control and reset must produce the same bubble.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            // NOTE: state registers use non-blocking assignments so every stage
            // samples its upstream value from before this edge.
            valid_q <= 1'b0;
            cbus_q  <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            cbus_q  <= cbus_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: rtl/cbus_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// cbus_pipe_ctrl
// Consumer end of the decoder control bus. Carries CBus and rd/rs1/rs2 of the
// ID instruction through the ID/EX, EX/MEM and MEM/WB registers, and produces
// the load-use stall, the branch/jump flush and the EX forwarding selects.
//   clk, rst                 clock and synchronous active-high reset
//   id_valid, id_cbus, id_rd, id_rs1, id_rs2   instruction in ID
//   ex_redirect              taken branch/jump resolved in EX this cycle
//   stall_fd                 hold PC and IF/ID (combinational)
//   flush_fd                 squash IF/ID (combinational)
//   ex_*  / mem_* / wb_*     stage register contents
//   fwd_a, fwd_b             EX operand select: 00 regfile, 01 MEM, 10 WB
// -----------------------------------------------------------------------------
module cbus_pipe_ctrl
    import cbus_pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [CBUS_W-1:0] id_cbus,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic              ex_redirect,
    output logic              stall_fd,
    output logic              flush_fd,
    output logic              ex_valid,
    output logic [CBUS_W-1:0] ex_cbus,
    output logic [RA_W-1:0]   ex_rd,
    output logic [RA_W-1:0]   ex_rs1,
    output logic [RA_W-1:0]   ex_rs2,
    output logic              mem_valid,
    output logic [CBUS_W-1:0] mem_cbus,
    output logic [RA_W-1:0]   mem_rd,
    output logic              wb_valid,
    output logic [CBUS_W-1:0] wb_cbus,
    output logic [RA_W-1:0]   wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic luse;
    logic id_bubble;

    // A load in EX whose result an ID source needs is not available until
    // it reaches WB, so ID must wait one cycle.
    assign luse = ex_valid && ex_cbus[CB_REGWEN]
               && (ex_cbus[CB_DSEL_HI:CB_DSEL_LO] == DSEL_MEM)
               && (ex_rd != '0) && id_valid
               && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Redirect squashes the wrong-path ID instruction; a stall inserts a
    // bubble while ID is held upstream. Both cases load a bubble into ID/EX.
    assign id_bubble = ex_redirect || luse || !id_valid;
    assign flush_fd  = ex_redirect;

    cbus_stage_reg u_idex (
        .clk     (clk),
        .rst     (rst),
        .bubble  (id_bubble),
        .valid_d (id_valid),
        .cbus_d  (id_cbus),
        .rd_d    (id_rd),
        .valid_q (ex_valid),
        .cbus_q  (ex_cbus),
        .rd_q    (ex_rd)
    );

    always_ff @(posedge clk) begin
        if (rst || id_bubble) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else begin
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
        end
    end

    // EX/MEM and MEM/WB always advance; the instruction in EX is never
    // squashed by its own redirect.
    cbus_stage_reg u_exmem (
        .clk     (clk),
        .rst     (rst),
        .bubble  (!ex_valid),
        .valid_d (ex_valid),
        .cbus_d  (ex_cbus),
        .rd_d    (ex_rd),
        .valid_q (mem_valid),
        .cbus_q  (mem_cbus),
        .rd_q    (mem_rd)
    );

    cbus_stage_reg u_memwb (
        .clk     (clk),
        .rst     (rst),
        .bubble  (!mem_valid),
        .valid_d (mem_valid),
        .cbus_d  (mem_cbus),
        .rd_d    (mem_rd),
        .valid_q (wb_valid),
        .cbus_q  (wb_cbus),
        .rd_q    (wb_rd)
    );

    // NOTE: every output gets a default before the conditional logic so the
    // block stays purely combinational.
    always_comb begin
        stall_fd = 1'b0;
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
        if (!rst) begin
            // A redirect discards the dependent instruction, so no stall.
            stall_fd = luse && !ex_redirect;
            fwd_a    = fwd_pick(ex_valid, ex_rs1,
                                mem_valid && mem_cbus[CB_REGWEN], mem_rd,
                                wb_valid && wb_cbus[CB_REGWEN], wb_rd);
            fwd_b    = fwd_pick(ex_valid, ex_rs2,
                                mem_valid && mem_cbus[CB_REGWEN], mem_rd,
                                wb_valid && wb_cbus[CB_REGWEN], wb_rd);
        end
    end

endmodule

// File: tb/tb_cbus_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cbus_pipe_ctrl
// Directed stimulus with a scoreboard: each issued instruction pushes its
// expected EX view (cbus, rd, forwarding selects) and, if it should retire,
// its expected WB view. A monitor pops and compares whenever ex_valid or
// wb_valid is seen. Stall/flush and reset state are checked inline.
// -----------------------------------------------------------------------------
module tb_cbus_pipe_ctrl;

    localparam logic [17:0] C_ADD = 18'h00021;  // ImmSrc=1, RegWEn
    localparam logic [17:0] C_SUB = 18'h00221;  // ADD plus ALUop bit
    localparam logic [17:0] C_LW  = 18'h000A0;  // RegWEn, DdataSel=01
    localparam logic [17:0] C_NOP = 18'h00000;
    localparam logic [1:0]  F_RF  = 2'b00;
    localparam logic [1:0]  F_MEM = 2'b01;
    localparam logic [1:0]  F_WB  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [17:0] id_cbus;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic        ex_redirect;
    logic        stall_fd, flush_fd;
    logic        ex_valid, mem_valid, wb_valid;
    logic [17:0] ex_cbus, mem_cbus, wb_cbus;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic [1:0]  fwd_a, fwd_b;

    typedef struct {
        logic [17:0] cbus;
        logic [4:0]  rd;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } ex_exp_t;

    typedef struct {
        logic [17:0] cbus;
        logic [4:0]  rd;
    } wb_exp_t;

    ex_exp_t ex_q[$];
    wb_exp_t wb_q[$];

    int tests = 0;
    int fails = 0;

    cbus_pipe_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_cbus     (id_cbus),
        .id_rd       (id_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_redirect (ex_redirect),
        .stall_fd    (stall_fd),
        .flush_fd    (flush_fd),
        .ex_valid    (ex_valid),
        .ex_cbus     (ex_cbus),
        .ex_rd       (ex_rd),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .mem_valid   (mem_valid),
        .mem_cbus    (mem_cbus),
        .mem_rd      (mem_rd),
        .wb_valid    (wb_valid),
        .wb_cbus     (wb_cbus),
        .wb_rd       (wb_rd),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        ex_exp_t e;
        wb_exp_t w;
        if (ex_valid === 1'b1) begin
            if (ex_q.size() == 0) begin
                check("ex_unexpected_valid", 32'(ex_valid), 32'd0);
            end else begin
                e = ex_q.pop_front();
                check("ex_cbus", 32'(ex_cbus), 32'(e.cbus));
                check("ex_rd",   32'(ex_rd),   32'(e.rd));
                check("fwd_a",   32'(fwd_a),   32'(e.fa));
                check("fwd_b",   32'(fwd_b),   32'(e.fb));
            end
        end
        if (wb_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected_valid", 32'(wb_valid), 32'd0);
            end else begin
                w = wb_q.pop_front();
                check("wb_cbus", 32'(wb_cbus), 32'(w.cbus));
                check("wb_rd",   32'(wb_rd),   32'(w.rd));
            end
        end
    end

    task automatic drive(input logic v, input logic [17:0] cb, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid = v;
        id_cbus  = cb;
        id_rd    = rd;
        id_rs1   = rs1;
        id_rs2   = rs2;
    endtask

    // One clock: check the combinational hazard outputs, then advance.
    task automatic step(input logic exp_stall, input logic exp_flush);
        @(negedge clk);
        check("stall_fd", 32'(stall_fd), 32'(exp_stall));
        check("flush_fd", 32'(flush_fd), 32'(exp_flush));
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [17:0] cb, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] fa, input logic [1:0] fb, input bit retire);
        drive(1'b1, cb, rd, rs1, rs2);
        ex_q.push_back('{cbus: cb, rd: rd, fa: fa, fb: fb});
        if (retire)
            wb_q.push_back('{cbus: cb, rd: rd});
        step(1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        drive(1'b0, 18'h0, 5'd0, 5'd0, 5'd0);
        repeat (n) step(1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held two cycles with a valid ID instruction
        rst = 1'b1;
        ex_redirect = 1'b0;
        drive(1'b1, C_ADD, 5'd5, 5'd5, 5'd5);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ex_valid",  32'(ex_valid),  32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_wb_valid",  32'(wb_valid),  32'd0);
        check("rst_ex_cbus",   32'(ex_cbus),   32'd0);
        check("rst_wb_cbus",   32'(wb_cbus),   32'd0);
        check("rst_ex_rd",     32'(ex_rd),     32'd0);
        check("rst_stall",     32'(stall_fd),  32'd0);
        check("rst_fwd_a",     32'(fwd_a),     32'(F_RF));
        check("rst_fwd_b",     32'(fwd_b),     32'(F_RF));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 2: single ADD flows EX -> MEM -> WB, one stage per edge
        issue(C_ADD, 5'd5, 5'd1, 5'd2, F_RF, F_RF, 1'b1);
        drive(1'b0, 18'h0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("flow_ex_valid", 32'(ex_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("flow_mem_valid", 32'(mem_valid), 32'd1);
        check("flow_mem_cbus",  32'(mem_cbus),  32'(C_ADD));
        check("flow_mem_rd",    32'(mem_rd),    32'd5);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("flow_wb_valid", 32'(wb_valid), 32'd1);
        @(posedge clk);
        #1;

        // 3: load-use stall, then WB forwarding of the load result
        issue(C_LW, 5'd5, 5'd1, 5'd0, F_RF, F_RF, 1'b1);
        drive(1'b1, C_ADD, 5'd7, 5'd5, 5'd2);
        step(1'b1, 1'b0);
        issue(C_ADD, 5'd7, 5'd5, 5'd2, F_WB, F_RF, 1'b1);
        idle(3);

        // 4a: back-to-back dependency -> MEM forwarding on both operands
        issue(C_ADD, 5'd6, 5'd1, 5'd2, F_RF, F_RF, 1'b1);
        issue(C_SUB, 5'd8, 5'd6, 5'd6, F_MEM, F_MEM, 1'b1);
        idle(3);
        // 4b: one NOP between -> WB forwarding
        issue(C_ADD, 5'd6, 5'd1, 5'd2, F_RF, F_RF, 1'b1);
        issue(C_NOP, 5'd0, 5'd0, 5'd0, F_RF, F_RF, 1'b1);
        issue(C_SUB, 5'd8, 5'd6, 5'd6, F_WB, F_WB, 1'b1);
        idle(3);
        // 4c: x6 in both MEM and WB -> younger (MEM) wins
        issue(C_ADD, 5'd6, 5'd1, 5'd2, F_RF, F_RF, 1'b1);
        issue(C_ADD, 5'd6, 5'd3, 5'd4, F_RF, F_RF, 1'b1);
        issue(C_SUB, 5'd8, 5'd6, 5'd6, F_MEM, F_MEM, 1'b1);
        idle(3);
        // 4d: producers writing x0 never forward
        issue(C_ADD, 5'd0, 5'd1, 5'd2, F_RF, F_RF, 1'b1);
        issue(C_ADD, 5'd0, 5'd3, 5'd4, F_RF, F_RF, 1'b1);
        issue(C_SUB, 5'd8, 5'd0, 5'd0, F_RF, F_RF, 1'b1);
        idle(3);

        // 5: redirect and load-use in the same cycle -> flush wins, no stall
        issue(C_LW, 5'd5, 5'd1, 5'd0, F_RF, F_RF, 1'b1);
        drive(1'b1, C_ADD, 5'd7, 5'd5, 5'd2);
        ex_redirect = 1'b1;
        step(1'b0, 1'b1);
        ex_redirect = 1'b0;
        idle(3);

        // 6: reset pulse with valid instructions in EX, MEM and WB
        issue(C_ADD, 5'd9,  5'd1, 5'd2, F_RF, F_RF, 1'b1);
        issue(C_ADD, 5'd10, 5'd3, 5'd4, F_RF, F_RF, 1'b0);
        // forwarding is forced to regfile while rst is high
        issue(C_ADD, 5'd11, 5'd9, 5'd0, F_RF, F_RF, 1'b0);
        rst = 1'b1;
        drive(1'b1, C_ADD, 5'd12, 5'd11, 5'd10);
        step(1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 18'h0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("rstp_ex_valid",  32'(ex_valid),  32'd0);
        check("rstp_mem_valid", 32'(mem_valid), 32'd0);
        check("rstp_wb_valid",  32'(wb_valid),  32'd0);
        check("rstp_mem_cbus",  32'(mem_cbus),  32'd0);
        check("rstp_wb_cbus",   32'(wb_cbus),   32'd0);
        @(posedge clk);
        #1;
        idle(3);

        check("ex_q_left", 32'(ex_q.size()), 32'd0);
        check("wb_q_left", 32'(wb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
